// File: rtl/packet_dispatch_fifo.sv
// Packet FIFO between packet SRAM and NUM_PE lanes; head steered by its dest field, one-cycle push-to-head latency.
// Optional statistics outputs enabled by `define PKT_FIFO_STATS_EN (counters survive flush, cleared by reset).
module packet_dispatch_fifo #(
  parameter int PKT_W    = 64,
  parameter int DEPTH    = 16,
  parameter int NUM_PE   = 4,
  parameter int DEST_LSB = 56,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [PKT_W-1:0]           in_packet,
  output logic                       full,
  output logic                       almost_full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [PKT_W-1:0]           out_packet,
  output logic [NUM_PE-1:0]          out_valid,
  input  logic [NUM_PE-1:0]          pe_ready,
  output logic                       overflow,
`ifdef PKT_FIFO_STATS_EN
  output logic [31:0]                push_cnt,
  output logic [15:0]                drop_cnt,
  output logic [NUM_PE*16-1:0]       lane_pop_cnt,
`endif
  output logic                       dest_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(NUM_PE);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d, dest_err_q, dest_err_d;
  logic [DW-1:0]    dest;
  logic             dest_ok, push, pop, bad_head, clr;

  assign clr         = reset || flush;
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign dest_err    = dest_err_q;
  assign out_packet  = mem_q[rd_ptr_q];
  assign dest        = out_packet[DEST_LSB +: DW];

  // Out-of-range destinations only exist when NUM_PE is not a power of two.
  generate
    if (NUM_PE == (1 << DW)) begin : g_pow2
      assign dest_ok = 1'b1;
    end else begin : g_npow2
      assign dest_ok = (32'(dest) < NUM_PE);
    end
  endgenerate

  always_comb begin
    out_valid = '0;
    if (!empty && dest_ok) out_valid[dest] = 1'b1;
  end

  assign bad_head = !empty && !dest_ok;
  assign push     = in_valid && !full;
  assign pop      = (|(out_valid & pe_ready)) || bad_head;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (in_valid && full);
    dest_err_d = dest_err_q || bad_head;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      dest_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q   <= wr_ptr_d;
    rd_ptr_q   <= rd_ptr_d;
    count_q    <= count_d;
    overflow_q <= overflow_d;
    dest_err_q <= dest_err_d;
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= in_packet;
  end

`ifdef PKT_FIFO_STATS_EN
  logic [31:0]          push_cnt_q, push_cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic [NUM_PE*16-1:0] lane_q, lane_d;
  logic [16:0]          drop_sum;
  logic [1:0]           drop_inc;

  assign push_cnt     = push_cnt_q;
  assign drop_cnt     = drop_cnt_q;
  assign lane_pop_cnt = lane_q;
  assign drop_inc     = {1'b0, in_valid && full} + {1'b0, bad_head};
  assign drop_sum     = {1'b0, drop_cnt_q} + 17'(drop_inc);

  // Flush blocks counting of the cycle it discards but never clears the totals.
  always_comb begin
    push_cnt_d = push_cnt_q;
    drop_cnt_d = drop_cnt_q;
    lane_d     = lane_q;
    if (!flush) begin
      if (push && push_cnt_q != '1) push_cnt_d = push_cnt_q + 32'd1;
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      for (int l = 0; l < NUM_PE; l++) begin
        if (out_valid[l] && pe_ready[l] && lane_q[l*16 +: 16] != 16'hFFFF)
          lane_d[l*16 +: 16] = lane_q[l*16 +: 16] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push_cnt_q <= '0;
      drop_cnt_q <= '0;
      lane_q     <= '0;
    end else begin
      push_cnt_q <= push_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      lane_q     <= lane_d;
    end
  end
`endif
endmodule

// File: doc/packet_dispatch_fifo.md
Name: packet_dispatch_fifo

Overview:
- Downstream stage of the packet memory controller.
- Buffers packets streamed out of packet SRAM (the controller's mem2fifo valid/packet pair) and returns the `full` backpressure that gates the controller's SRAM reads.
- Steers each head-of-line packet to one of NUM_PE processing elements, selected by a destination field inside the packet, using a per-PE valid/ready handshake.
- Cleared by the replay-iteration flag, in lock-step with the controller's address reset.

Parameters:
- PKT_W, 64: packet width in bits (equals `packet_size`).
- DEPTH, 16: FIFO entries; power of two, ≥ 4.
- NUM_PE, 4: number of PE output lanes, ≥ 2.
- DEST_LSB, 56: LSB of the destination field inside the packet. The field is DW = $clog2(NUM_PE) bits wide.
- AF_LEVEL, DEPTH-2: occupancy at which `almost_full` asserts.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear (driven by replay_iter_flag)
- in_valid  in  1  push strobe (mem2fifo.valid)
- in_packet  in  PKT_W  push data (mem2fifo.packet)
- full  out  1  count == DEPTH; combinational from registered count
- almost_full  out  1  count >= AF_LEVEL
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  current occupancy
- out_packet  out  PKT_W  head entry, broadcast to all lanes
- out_valid  out  NUM_PE  one-hot; bit d set when head is valid and its dest == d
- pe_ready  in  NUM_PE  per-lane accept
- overflow  out  1  sticky: push attempted while full
- dest_err  out  1  sticky: head dest field >= NUM_PE

Behaviour:
- Reset/flush (flush treated exactly like reset):
  - Pointers and count go to 0; overflow and dest_err go to 0.
  - Outputs after reset: empty=1, full=0, almost_full=0, out_valid=0, count=0.
  - out_packet is don't-care while empty.
  - Reset/flush wins over any push or pop in the same cycle.
- Storage: circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0. Count is tracked separately; no pointer-equality ambiguity.
- Push: accepted when in_valid && !full. Data is written at wr_ptr; wr_ptr and count increment.
- Push while full: packet dropped, overflow <= 1, no state change. A push is refused on a full cycle even if a pop occurs in that same cycle (full is evaluated before the pop).
- Head decode: dest = out_packet[DEST_LSB +: DW] of mem[rd_ptr].
  - If !empty and dest < NUM_PE: out_valid = 1 << dest.
  - Otherwise out_valid = 0.
- Pop: occurs when out_valid[dest] && pe_ready[dest]. rd_ptr increments and count decrements. pe_ready on non-selected lanes is ignored. Head-of-line blocking is intended: a non-ready destination stalls all lanes.
- Bad destination: if !empty and dest >= NUM_PE (only possible when NUM_PE is not a power of two):
  - Head is auto-discarded that cycle (pop without any out_valid).
  - dest_err <= 1.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Latency: a packet pushed into an empty FIFO appears on out_packet/out_valid in the next cycle. Fall-through is not permitted.
- Throughput: 1 push and 1 pop per cycle, sustained.
- Ordering: strict FIFO order across all lanes.
- out_packet/out_valid are driven from registered memory and pointers only; no combinational path from pe_ready to out_valid.
- full/count are registered-state derived, so the upstream controller can sample `full` in the same cycle it decides to read.

Optional Feature:
- Macro: PKT_FIFO_STATS_EN.
- When defined, three extra outputs are added:
  - push_cnt (32 b): accepted pushes.
  - drop_cnt (16 b): overflow plus dest_err drops.
  - lane_pop_cnt (NUM_PE x 16 b, packed): pops per lane.
- All counters saturate at their maximum, clear on reset, and are NOT cleared by flush, so statistics persist across replay iterations.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid=1 -> count=0, empty=1, out_valid=0, overflow=0 in the cycle after release.
- Steering: push 4 packets with dest=0,1,2,3 (payload 0xA0..0xA3), all pe_ready=1 -> out_valid = 0001, 0010, 0100, 1000 on consecutive cycles, starting the cycle after the first push; out_packet payloads in order.
- Fill and overflow: pe_ready=0, push 17 packets (DEPTH=16) -> full=1 after the 16th, almost_full=1 at count 14, 17th push dropped, overflow=1. Then pe_ready=all 1 -> exactly 16 packets drained in order.
- Head-of-line blocking: head dest=2 with pe_ready=1011, next packet dest=0 -> no pop and out_valid=0100 until pe_ready[2]=1, then the dest-0 packet follows on the next cycle.
- Wrap and simultaneous push/pop: continuous push and pop for 40 cycles -> count stays constant at 1, pointers wrap, no loss; packet sequence numbers match 0..39.
- Flush mid-stream: with count=7, assert flush together with in_valid=1 -> the following cycle shows count=0, empty=1, and the pushed packet is discarded. With PKT_FIFO_STATS_EN defined, push_cnt is retained.
